// File: rtl/button_conditioner_pkg.sv
// Shared game package: state enums and default constants used by the
// game-state logic and by the push-button conditioner.
package button_conditioner_pkg;

    localparam int NUM_BTN_DEFAULT         = 5;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 100000;

    // Top-level game flow, driven by the conditioned start/pause button.
    typedef enum logic [1:0] {
        GAME_IDLE,
        GAME_RUNNING,
        GAME_PAUSED,
        GAME_OVER
    } GAME_STATE;

    // Per-button debounce state.
    typedef enum logic [1:0] {
        RELEASED,
        ARMING,
        HELD,
        DISARMING
    } BTN_STATE;

    // A button counts as down once accepted, including while a release is
    // still being debounced.
    function automatic logic is_pressed(input BTN_STATE s);
        return (s == HELD) || (s == DISARMING);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus: raw pad inputs in, debounced levels and press pulses out.
interface button_conditioner_if
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEFAULT
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               any_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  any_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output any_pulse
    );

endinterface

// File: rtl/button_channel.sv
// One push-button channel: two-flop synchronizer, debounce FSM with a
// saturating counter, and registered level / single-press pulse outputs.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_ff;
    logic             sync;
    BTN_STATE         state;
    logic [CNT_W-1:0] cnt;
    logic             just_armed;

    assign sync = sync_ff[1];

    // Bring the asynchronous pad into the clock domain; only the second flop feeds the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], raw};
        end
    end

    // Debounce FSM; level and pulse are registered one cycle behind the state so a fresh press pulses exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RELEASED;
            cnt        <= '0;
            just_armed <= 1'b0;
            level      <= 1'b0;
            pulse      <= 1'b0;
        end else begin
            level      <= is_pressed(state);
            pulse      <= just_armed;
            just_armed <= 1'b0;
            case (state)
                RELEASED: begin
                    if (sync) begin
                        state <= ARMING;
                        cnt   <= '0;
                    end
                end
                ARMING: begin
                    if (!sync) begin
                        state <= RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state      <= HELD;
                        just_armed <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state <= DISARMING;
                        cnt   <= '0;
                    end
                end
                DISARMING: begin
                    if (sync) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= RELEASED;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: NUM_BTN independent debounced channels plus a
// combined press pulse for the game-state FSM.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    logic [NUM_BTN-1:0] level_vec;
    logic [NUM_BTN-1:0] pulse_vec;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_channel
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_channel (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.btn_raw[i]),
            .level (level_vec[i]),
            .pulse (pulse_vec[i])
        );
    end

    assign bus.btn_level = level_vec;
    assign bus.btn_pulse = pulse_vec;
    assign bus.any_pulse = |pulse_vec;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NUM_BTN, default 5, SHALL set the number of independent push-button channels; bit 0 is the start/pause button.
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000, SHALL set the stable-input cycles required before an edge is accepted; legal range is at least 2.
REQ-003 Parameter CNT_W, default $clog2(DEBOUNCE_CYCLES), SHALL set the debounce counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 btn_raw  input  NUM_BTN  SHALL carry the asynchronous, bouncing pad inputs, active-high.
REQ-007 btn_level  output  NUM_BTN  SHALL carry the debounced level per channel.
REQ-008 btn_pulse  output  NUM_BTN  SHALL carry a one-cycle pulse per accepted press.
REQ-009 any_pulse  output  1  SHALL be the OR of btn_pulse; it drives the game-state FSM's button input.

Function
REQ-010 Each channel SHALL pass btn_raw through a 2-flop synchronizer; the FSM SHALL use only the second flop's output (sync).
REQ-011 Each channel SHALL run a 4-state FSM: RELEASED, ARMING, HELD, DISARMING, with one CNT_W-bit counter.
REQ-012 RELEASED: sync=1 -> ARMING with cnt=0; otherwise stay.
REQ-013 ARMING: sync=0 -> RELEASED; sync=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; otherwise cnt+1.
REQ-014 HELD: sync=0 -> DISARMING with cnt=0; otherwise stay.
REQ-015 DISARMING: sync=1 -> HELD with no pulse; sync=0 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED; otherwise cnt+1.
REQ-016 btn_pulse[i] SHALL be a registered output, high for exactly the first cycle the channel is in HELD after an ARMING->HELD transition; a DISARMING->HELD return SHALL NOT pulse.
REQ-017 btn_level[i] SHALL be registered and high while the channel is in HELD or DISARMING.
REQ-018 Latency: with btn_raw[i] held high from clock edge k onward, btn_pulse[i] and btn_level[i] SHALL first be high in the cycle after edge k+DEBOUNCE_CYCLES+3.
REQ-019 Release latency: with btn_raw[i] low from edge k onward, btn_level[i] SHALL first be low in the cycle after edge k+DEBOUNCE_CYCLES+3.
REQ-020 Any glitch shorter than DEBOUNCE_CYCLES sync cycles SHALL restart the count and produce no pulse or level change.
REQ-021 Holding a button indefinitely SHALL produce exactly one pulse (no auto-repeat).
REQ-022 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-023 Channels SHALL be fully independent; simultaneous presses SHALL produce pulses in the same cycle on each channel; any_pulse SHALL be the same-cycle OR of those pulses.

Reset
REQ-024 While rst=1 at a clock edge, the synchronizer flops, counters, btn_level, btn_pulse and any_pulse SHALL clear to 0 and every FSM SHALL go to RELEASED.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL discard progress and emit no pulse.
REQ-026 A button still held when rst deasserts SHALL be treated as a new press: one pulse after the full REQ-018 latency.

Structure
REQ-027 The BTN_STATE enum (RELEASED, ARMING, HELD, DISARMING) SHALL live in the shared game package beside GAME_STATE.
REQ-028 The default DEBOUNCE_CYCLES constant SHALL live in the shared package.
REQ-029 Per-channel logic (synchronizer, FSM, counter, pulse register) SHALL be the sub-module button_channel.
REQ-030 The top level SHALL instantiate button_channel NUM_BTN times in a generate loop and form any_pulse.

Verification (DEBOUNCE_CYCLES=4, NUM_BTN=5)
REQ-031 Clean press: btn_raw[0] high from edge 0 -> btn_pulse[0]=1 and any_pulse=1 only in the cycle after edge 7; btn_level[0]=1 from then on.
REQ-032 Bounce: btn_raw[0] toggles 1,0,1,0 on edges 0-3, then holds 1 -> exactly one pulse, 7 cycles after the last rising toggle.
REQ-033 Short release: after HELD, btn_raw[0] is low for 3 cycles, then high -> btn_level stays 1 and no second pulse.
REQ-034 Simultaneous: btn_raw[4:0] = 5'b10011 at edge 0 -> btn_pulse = 5'b10011 in the same cycle; any_pulse high for one cycle.
REQ-035 Reset mid-arm: rst=1 at edge 4 of a press -> all outputs 0; with the button still held after rst falls at edge 5, the pulse follows 7 cycles later.
REQ-036 Long hold for 1000 cycles -> exactly one pulse; release -> btn_level falls 7 cycles after release.
